// File: rtl/mycpu_pkg.sv
// mycpu_pkg
// Shared definitions for the mycpu datapath control unit:
//   cu_state_t  - control unit sequencer states
//   opcode_t    - 7-bit opcode encodings
//   FS_*        - ALU function select codes
//   ps_sel_t    - PC select encodings
//   md_sel_t    - destination data mux encodings
//   alu_decode  - maps an opcode to its ALU function (ALU-class opcodes only)
package mycpu_pkg;

  typedef enum logic [2:0] {
    RST  = 3'd0,
    INF  = 3'd1,
    EX0  = 3'd2,
    XSH  = 3'd3,
    IOW8 = 3'd4,
    HLT  = 3'd5
  } cu_state_t;

  typedef enum logic [6:0] {
    MOVA = 7'h00,
    INC  = 7'h01,
    ADD  = 7'h02,
    CLR  = 7'h03,
    SUB  = 7'h05,
    DEC  = 7'h06,
    AND  = 7'h08,
    OR   = 7'h09,
    XOR  = 7'h0A,
    NOT  = 7'h0B,
    MOVB = 7'h0C,
    SHR  = 7'h0D,
    SHX  = 7'h0E,
    SHL  = 7'h0F,
    LD   = 7'h10,
    ST   = 7'h20,
    IOR  = 7'h30,
    IOW  = 7'h31,
    ADI  = 7'h42,
    LDI  = 7'h4C,
    BRZ  = 7'h60,
    BRN  = 7'h61,
    JMP  = 7'h70,
    HAL  = 7'h7F
  } opcode_t;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_INC  = 4'b0001;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_DEC  = 4'b0110;
  localparam logic [3:0] FS_CLR  = 4'b0111;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SHL  = 4'b1101;
  localparam logic [3:0] FS_SHR  = 4'b1110;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_JUMP   = 2'b11
  } ps_sel_t;

  typedef enum logic [1:0] {
    MD_ALU = 2'b00,
    MD_MEM = 2'b01,
    MD_IO  = 2'b10
  } md_sel_t;

  typedef struct packed {
    logic       hit;
    logic       imm;
    logic [3:0] fs;
  } alu_dec_t;

  // ALU-class opcodes all share the same control pattern (write DR, advance
  // PC); only the function code and the immediate B-bus select differ.
  function automatic alu_dec_t alu_decode(input logic [6:0] op);
    alu_dec_t d;
    d.hit = 1'b1;
    d.imm = 1'b0;
    d.fs  = FS_MOVA;
    case (op)
      MOVA: d.fs = FS_MOVA;
      INC:  d.fs = FS_INC;
      ADD:  d.fs = FS_ADD;
      SUB:  d.fs = FS_SUB;
      DEC:  d.fs = FS_DEC;
      AND:  d.fs = FS_AND;
      OR:   d.fs = FS_OR;
      XOR:  d.fs = FS_XOR;
      NOT:  d.fs = FS_NOT;
      MOVB: d.fs = FS_MOVB;
      SHR:  d.fs = FS_SHR;
      SHL:  d.fs = FS_SHL;
      CLR:  d.fs = FS_CLR;
      LDI: begin
        d.fs  = FS_MOVB;
        d.imm = 1'b1;
      end
      ADI: begin
        d.fs  = FS_ADD;
        d.imm = 1'b1;
      end
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cu_mc.sv
// cu_mc
// Multicycle control unit for the mycpu datapath. Sequences fetch/execute,
// decodes the opcode field and drives the datapath control bus.
//
// Optional feature macro: CU_IOWAIT_EN
//   defined   - IOR/IOW wait in IOW8 for io_rdy_in before completing
//   undefined - IOR/IOW complete in EX0, io_rdy_in is ignored
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ins_in        instruction register contents {opcode, DR, SA, SB}
//   z_in, n_in    ALU zero / negative flags
//   io_rdy_in     IO device ready
//   run_in        restart request while halted
//   il_out        instruction register load
//   ps_out        PC select (hold / increment / branch / jump)
//   rw_out        register file write
//   rs_out        register selects {0,DR,0,SA,0,SB}
//   mm_out        memory address mux
//   md_out        destination data mux (ALU / memory / IO)
//   mb_out        B-bus immediate select
//   fs_out        ALU function select
//   wen_out       memory/IO write enable, active low
//   iom_out       IO space select
//   halted_out    high while halted
//   illegal_out   one-cycle pulse on an undefined opcode
module cu_mc
  import mycpu_pkg::*;
#(
  parameter int OPW = 7,
  parameter int RAW = 3,
  parameter int IW  = OPW + 3 * RAW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        ins_in,
  input  logic                 z_in,
  input  logic                 n_in,
  input  logic                 io_rdy_in,
  input  logic                 run_in,
  output logic                 il_out,
  output logic [1:0]           ps_out,
  output logic                 rw_out,
  output logic [3*(RAW+1)-1:0] rs_out,
  output logic                 mm_out,
  output logic [1:0]           md_out,
  output logic                 mb_out,
  output logic [3:0]           fs_out,
  output logic                 wen_out,
  output logic                 iom_out,
  output logic                 halted_out,
  output logic                 illegal_out
);

  if (IW != OPW + 3 * RAW) begin : gBadIw
    $error("cu_mc: IW must equal OPW + 3*RAW");
  end

  cu_state_t          st_q, st_d;
  logic [RAW-1:0]     cnt_q, cnt_d;

  logic [OPW-1:0]     opField;
  logic [6:0]         op7;
  logic               opFits;
  logic [RAW-1:0]     dr, sa, sb;
  logic [3*(RAW+1)-1:0] rsFields;
  alu_dec_t           aluDec;
  logic               unusedIoRdy;

  assign opField  = ins_in[IW-1 -: OPW];
  assign dr       = ins_in[3*RAW-1 -: RAW];
  assign sa       = ins_in[2*RAW-1 -: RAW];
  assign sb       = ins_in[RAW-1:0];
  assign rsFields = {1'b0, dr, 1'b0, sa, 1'b0, sb};

  // The opcode table is 7 bits wide. A wider opcode field only decodes when
  // its extra upper bits are zero; anything else is treated as undefined.
  assign op7    = 7'(opField);
  assign opFits = ((opField >> 7) == '0);
  assign aluDec = alu_decode(op7);

  assign unusedIoRdy = io_rdy_in;

  // State and shift counter; reset may land at any point, including
  // mid-shift or mid-IO wait, and always restarts from RST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RST;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state and control-bus decode. Every output starts from the idle
  // vector (PC hold, no writes, write enable inactive) and each state only
  // overrides what it needs.
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    il_out      = 1'b0;
    ps_out      = PS_HOLD;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = MD_ALU;
    mb_out      = 1'b0;
    fs_out      = FS_MOVA;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    halted_out  = 1'b0;
    illegal_out = 1'b0;

    case (st_q)
      RST: st_d = INF;

      INF: begin
        il_out = 1'b1;
        st_d   = EX0;
      end

      EX0: begin
        rs_out = rsFields;
        st_d   = INF;
        if (!opFits) begin
          illegal_out = 1'b1;
          ps_out      = PS_INC;
        end else if (aluDec.hit) begin
          rw_out = 1'b1;
          ps_out = PS_INC;
          fs_out = aluDec.fs;
          mb_out = aluDec.imm;
        end else begin
          case (op7)
            LD: begin
              md_out = MD_MEM;
              rw_out = 1'b1;
              ps_out = PS_INC;
            end
            ST: begin
              wen_out = 1'b0;
              ps_out  = PS_INC;
            end
            BRZ: ps_out = z_in ? PS_BRANCH : PS_INC;
            BRN: ps_out = n_in ? PS_BRANCH : PS_INC;
            JMP: ps_out = PS_JUMP;
            SHX: begin
              // A zero count is a plain NOP-like advance; otherwise the SB
              // field becomes the number of XSH cycles to run.
              if (sb == '0) begin
                ps_out = PS_INC;
              end else begin
                cnt_d = sb;
                st_d  = XSH;
              end
            end
            IOR: begin
              iom_out = 1'b1;
              md_out  = MD_IO;
`ifdef CU_IOWAIT_EN
              st_d    = IOW8;
`else
              rw_out  = 1'b1;
              ps_out  = PS_INC;
`endif
            end
            IOW: begin
              iom_out = 1'b1;
              wen_out = 1'b0;
`ifdef CU_IOWAIT_EN
              st_d    = IOW8;
`else
              ps_out  = PS_INC;
`endif
            end
            HAL: begin
              ps_out = PS_INC;
              st_d   = HLT;
            end
            default: begin
              illegal_out = 1'b1;
              ps_out      = PS_INC;
            end
          endcase
        end
      end

      XSH: begin
        // Shift DR in place one bit per cycle; the count never starts at
        // zero, but a zero is still treated as the last cycle so the unit
        // cannot get stuck here.
        rw_out = 1'b1;
        fs_out = FS_SHR;
        rs_out = {1'b0, dr, 1'b0, dr, {(RAW+1){1'b0}}};
        cnt_d  = cnt_q - RAW'(1);
        if (cnt_q <= RAW'(1)) begin
          ps_out = PS_INC;
          st_d   = INF;
        end
      end

      IOW8: begin
`ifdef CU_IOWAIT_EN
        // Strobes stay up for the whole wait; the register write for IOR
        // happens only in the cycle the device reports ready.
        rs_out  = rsFields;
        iom_out = 1'b1;
        if (opFits && (op7 == IOR)) begin
          md_out = MD_IO;
          rw_out = io_rdy_in;
        end else begin
          wen_out = 1'b0;
        end
        if (io_rdy_in) begin
          ps_out = PS_INC;
          st_d   = INF;
        end
`else
        st_d = INF;
`endif
      end

      HLT: begin
        halted_out = 1'b1;
        if (run_in) st_d = INF;
      end

      default: st_d = RST;
    endcase
  end

endmodule
